// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game obstacle path.
// Holds the obstacle type, the spawner state encoding and the LFSR tap mask.
package dino_pkg;

    typedef logic [1:0] cactus_type_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ARMED
    } spawn_state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR, shared by the game's random consumers.
// Ports: clk_i, rst_ni (async low), en_i step enable, value_o current state.
import dino_pkg::*;

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] value_o
);

    // An all-zero state would lock up the register.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h0001 : SEED;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_o <= SEED_NZ;
        end else if (en_i) begin
            value_o <= {1'b0, value_o[15:1]}
                     ^ (value_o[0] ? LFSR_MASK : 16'h0);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Frame-paced obstacle spawner: random gap, one-frame spawn pulse, difficulty.
// Ports: clk_i, rst_ni, next_frame_i, run_i -> spawn_o, rand_o, level_o.
import dino_pkg::*;

module obstacle_spawner #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          START_GAP    = 30,
    parameter int          MIN_GAP      = 40,
    parameter int          GAP_STEP     = 4,
    parameter int          GAP_FLOOR    = 16,
    parameter int          LEVEL_FRAMES = 600
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         next_frame_i,
    input  logic         run_i,
    output logic         spawn_o,
    output cactus_type_t rand_o,
    output logic [2:0]   level_o
);

    localparam int CW =
        (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEVEL_FRAMES - 1);

    spawn_state_e  state_q, state_d;
    logic [6:0]    gap_q, gap_d;
    logic [2:0]    level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          spawn_q, spawn_d;
    cactus_type_t  rand_q, rand_d;

    logic [15:0]   lfsr;
    logic [6:0]    eff_min;
    int            gap_cut;
    logic          unused_lfsr;

    assign unused_lfsr = ^lfsr[15:8];

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .value_o(lfsr)
    );

    // Compare before subtracting so a high level never wraps below zero.
    always_comb begin
        gap_cut = GAP_STEP * int'(level_q);
        if (MIN_GAP <= GAP_FLOOR + gap_cut) begin
            eff_min = 7'(GAP_FLOOR);
        end else begin
            eff_min = 7'(MIN_GAP - gap_cut);
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        spawn_d = spawn_q;
        rand_d  = rand_q;

        unique case (state_q)
            IDLE: begin
                spawn_d = 1'b0;
                gap_d   = 7'(START_GAP);
                level_d = 3'd0;
                cnt_d   = '0;
                if (run_i) state_d = WAIT;
            end
            WAIT: begin
                if (next_frame_i) begin
                    if (gap_q == 7'd0) begin
                        state_d = ARMED;
                        spawn_d = 1'b1;
                        rand_d  = lfsr[7:6];
                    end else begin
                        gap_d = gap_q - 7'd1;
                    end
                end
            end
            ARMED: begin
                if (next_frame_i) begin
                    state_d = WAIT;
                    spawn_d = 1'b0;
                    gap_d   = eff_min + {1'b0, lfsr[5:0]};
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && next_frame_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (level_q != 3'd7) level_d = level_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Leaving the game beats any frame work in the same cycle.
        if (!run_i) begin
            state_d = IDLE;
            spawn_d = 1'b0;
            gap_d   = 7'(START_GAP);
            level_d = 3'd0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= 7'(START_GAP);
            level_q <= 3'd0;
            cnt_q   <= '0;
            spawn_q <= 1'b0;
            rand_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            spawn_q <= spawn_d;
            rand_q  <= rand_d;
        end
    end

    assign spawn_o = spawn_q;
    assign rand_o  = rand_q;
    assign level_o = level_q;

endmodule
